// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline memory stage. It runs loads and stores on a req/ready
//               data bus, steers store bytes onto the lanes, and extracts and
//               extends load lanes. It holds the upstream pipeline while a
//               transaction is in flight and registers the MEM/WB values.
//               Optional macro MEM_ALIGN_CHECK_EN enables misalignment
//               trapping: no bus request is made and o_Misaligned pulses.
//               Only DATA_WIDTH = 32 is supported.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_MASK_WIDTH = 3
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic [DATA_WIDTH-1:0]     i_ALU_Result,
    input  logic                      i_Mem_Valid,
    input  logic [MEM_MASK_WIDTH-1:0] i_Mem_Mask,
    input  logic                      i_Mem_Read_Write_n,
    input  logic [DATA_WIDTH-1:0]     i_Mem_Write_Data,
    input  logic                      i_Writes_Back,
    input  logic [REG_ADDR_WIDTH-1:0] i_Write_Addr,
    output logic                      o_Stall,
    output logic                      o_Mem_Req,
    output logic [ADDRESS_WIDTH-1:0]  o_Mem_Addr,
    output logic                      o_Mem_Read_Write_n,
    output logic [DATA_WIDTH/8-1:0]   o_Mem_Byte_En,
    output logic [DATA_WIDTH-1:0]     o_Mem_Write_Data,
    input  logic                      i_Mem_Ready,
    input  logic [DATA_WIDTH-1:0]     i_Mem_Read_Data,
    output logic [DATA_WIDTH-1:0]     o_WB_Data,
    output logic                      o_Writes_Back,
    output logic [REG_ADDR_WIDTH-1:0] o_Write_Addr,
    output logic                      o_Misaligned
);

    localparam int BE_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [1:0]                lane_sel;   // address low bits of the access in flight
    logic [MEM_MASK_WIDTH-1:0] acc_mask;   // size/sign code of the access in flight
    logic [DATA_WIDTH-1:0]     load_data;  // extracted load result held for DONE
    logic                      misaligned_now;
    logic                      issue;

    // Byte-lane enables for the requested access size
    function automatic logic [BE_W-1:0] lane_enables(input logic [1:0] size,
                                                     input logic [1:0] a);
        logic [BE_W-1:0] be;
        case (size)
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across every lane it may land on
    function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [1:0] size,
                                                        input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        case (size)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Select the addressed lane of read data and sign- or zero-extend it
    function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0]     d,
                                                      input logic [1:0]                a,
                                                      input logic [MEM_MASK_WIDTH-1:0] m);
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (m[1:0])
            2'b00:   r = m[2] ? {{(DATA_WIDTH-8){1'b0}}, b}  : {{(DATA_WIDTH-8){b[7]}}, b};
            2'b01:   r = m[2] ? {{(DATA_WIDTH-16){1'b0}}, h} : {{(DATA_WIDTH-16){h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef MEM_ALIGN_CHECK_EN
    // Half accesses need an even address, word accesses a 4-byte aligned one
    always_comb begin
        misaligned_now = 1'b0;
        case (i_Mem_Mask[1:0])
            2'b00:   misaligned_now = 1'b0;
            2'b01:   misaligned_now = i_ALU_Result[0];
            default: misaligned_now = |i_ALU_Result[1:0];
        endcase
    end
`else
    assign misaligned_now = 1'b0;
`endif

    // A valid, correctly aligned memory op seen in IDLE starts a bus transaction
    assign issue = (state == IDLE) && i_Mem_Valid && !misaligned_now;

    // Stall is held through issue and the whole BUSY phase; reset forces it low
    assign o_Stall = !i_Reset && (issue || (state == BUSY));

    // Stage FSM with registered bus and MEM/WB outputs
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state              <= IDLE;
            lane_sel           <= 2'b00;
            acc_mask           <= '0;
            load_data          <= '0;
            o_Mem_Req          <= 1'b0;
            o_Mem_Addr         <= '0;
            o_Mem_Read_Write_n <= 1'b0;
            o_Mem_Byte_En      <= '0;
            o_Mem_Write_Data   <= '0;
            o_WB_Data          <= '0;
            o_Writes_Back      <= 1'b0;
            o_Write_Addr       <= '0;
            o_Misaligned       <= 1'b0;
        end else begin
            o_Misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_Mem_Valid) begin
                        // Memory ops reach writeback only from DONE or as a trap bubble
                        o_WB_Data     <= '0;
                        o_Writes_Back <= 1'b0;
                        o_Write_Addr  <= '0;
                        if (misaligned_now) begin
                            o_Misaligned <= 1'b1;
                        end else begin
                            o_Mem_Req          <= 1'b1;
                            o_Mem_Addr         <= {i_ALU_Result[ADDRESS_WIDTH-1:2], 2'b00};
                            o_Mem_Read_Write_n <= i_Mem_Read_Write_n;
                            o_Mem_Byte_En      <= lane_enables(i_Mem_Mask[1:0], i_ALU_Result[1:0]);
                            o_Mem_Write_Data   <= lane_data(i_Mem_Mask[1:0], i_Mem_Write_Data);
                            lane_sel           <= i_ALU_Result[1:0];
                            acc_mask           <= i_Mem_Mask;
                            state              <= BUSY;
                        end
                    end else begin
                        o_WB_Data     <= i_ALU_Result;
                        o_Writes_Back <= i_Writes_Back;
                        o_Write_Addr  <= i_Write_Addr;
                    end
                end
                BUSY: begin
                    o_WB_Data     <= '0;
                    o_Writes_Back <= 1'b0;
                    o_Write_Addr  <= '0;
                    if (i_Mem_Ready) begin
                        o_Mem_Req <= 1'b0;
                        load_data <= extract(i_Mem_Read_Data, lane_sel, acc_mask);
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // The registered bus direction tells load from store
                    o_WB_Data     <= o_Mem_Read_Write_n ? load_data : i_ALU_Result;
                    o_Writes_Back <= i_Writes_Back;
                    o_Write_Addr  <= i_Write_Addr;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed self-checking bench for mem_access_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic [31:0] alu;
    logic        valid;
    logic [2:0]  mask;
    logic        rw;
    logic [31:0] wdata;
    logic        wb_in;
    logic [4:0]  waddr_in;
    logic        stall;
    logic        req;
    logic [31:0] mem_addr;
    logic        mem_rw;
    logic [3:0]  be;
    logic [31:0] mem_wd;
    logic        ready;
    logic [31:0] rdata;
    logic [31:0] wb_data;
    logic        wb_out;
    logic [4:0]  waddr_out;
    logic        misaligned;

    int checks = 0;
    int errors = 0;
    int req_starts = 0;
    logic prev_req = 1'b0;

    mem_access_stage dut (
        .i_Clk              (clk),
        .i_Reset            (rst),
        .i_ALU_Result       (alu),
        .i_Mem_Valid        (valid),
        .i_Mem_Mask         (mask),
        .i_Mem_Read_Write_n (rw),
        .i_Mem_Write_Data   (wdata),
        .i_Writes_Back      (wb_in),
        .i_Write_Addr       (waddr_in),
        .o_Stall            (stall),
        .o_Mem_Req          (req),
        .o_Mem_Addr         (mem_addr),
        .o_Mem_Read_Write_n (mem_rw),
        .o_Mem_Byte_En      (be),
        .o_Mem_Write_Data   (mem_wd),
        .i_Mem_Ready        (ready),
        .i_Mem_Read_Data    (rdata),
        .o_WB_Data          (wb_data),
        .o_Writes_Back      (wb_out),
        .o_Write_Addr       (waddr_out),
        .o_Misaligned       (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges of the bus request
    always @(posedge clk) begin
        prev_req <= req;
        if (req && !prev_req) req_starts <= req_starts + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 0; mask = 3'b000; rw = 0; wdata = 0; wb_in = 0; waddr_in = 0;
        alu = 0; ready = 0; rdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", req); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h exp 0", wb_data); end
        checks++; if (wb_out !== 1'b0 || waddr_out !== 5'd0) begin errors++; $display("FAIL reset_wb_ctrl: got %b/%0d exp 0/0", wb_out, waddr_out); end
        checks++; if (be !== 4'h0 || mem_addr !== 32'h0 || misaligned !== 1'b0) begin errors++; $display("FAIL reset_bus: got be=%b addr=%h mis=%b exp 0", be, mem_addr, misaligned); end
        rst = 0;
        tick();
    endtask

    task automatic test_non_mem();
        alu = 32'h1234; wb_in = 1; waddr_in = 5; valid = 0; ready = 1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nonmem_stall: got %b exp 0", stall); end
        tick();
        checks++; if (wb_data !== 32'h1234) begin errors++; $display("FAIL nonmem_data: got %h exp 00001234", wb_data); end
        checks++; if (wb_out !== 1'b1 || waddr_out !== 5'd5) begin errors++; $display("FAIL nonmem_ctrl: got %b/%0d exp 1/5", wb_out, waddr_out); end
        checks++; if (stall !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL nonmem_nostall: got stall=%b req=%b exp 0/0", stall, req); end
        idle_inputs();
    endtask

    task automatic test_signed_byte_load();
        int stall_cycles;
        stall_cycles = 0;
        alu = 32'h103; valid = 1; mask = 3'b000; rw = 1; wb_in = 1; waddr_in = 7;
        rdata = 32'h80FF_FF00; ready = 0;
        #1;
        if (stall) stall_cycles++;
        tick();
        checks++; if (req !== 1'b1 || be !== 4'b1000 || mem_addr !== 32'h100 || mem_rw !== 1'b1) begin errors++; $display("FAIL sbl_bus: got req=%b be=%b addr=%h rw=%b exp 1/1000/00000100/1", req, be, mem_addr, mem_rw); end
        checks++; if (wb_out !== 1'b0) begin errors++; $display("FAIL sbl_bubble: got %b exp 0", wb_out); end
        if (stall) stall_cycles++;
        ready = 1;
        tick();
        ready = 0;
        if (stall) stall_cycles++;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL sbl_req_clear: got %b exp 0", req); end
        tick();
        checks++; if (wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL sbl_data: got %h exp ffffff80", wb_data); end
        checks++; if (wb_out !== 1'b1 || waddr_out !== 5'd7) begin errors++; $display("FAIL sbl_ctrl: got %b/%0d exp 1/7", wb_out, waddr_out); end
        checks++; if (stall_cycles != 2) begin errors++; $display("FAIL sbl_stall_cycles: got %0d exp 2", stall_cycles); end
        idle_inputs();
        tick();
    endtask

    task automatic test_half_store();
        int stall_cycles;
        int req_cycles;
        stall_cycles = 0; req_cycles = 0;
        alu = 32'h202; valid = 1; mask = 3'b001; rw = 0; wdata = 32'h0000_ABCD; wb_in = 0;
        ready = 0;
        #1;
        if (stall) stall_cycles++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (stall) stall_cycles++;
            if (req === 1'b1 && be === 4'b1100 && mem_wd === 32'hABCD_ABCD && mem_addr === 32'h200 && mem_rw === 1'b0) req_cycles++;
            ready = (i == 3);
        end
        tick();
        ready = 0;
        if (stall) stall_cycles++;
        checks++; if (req_cycles != 4) begin errors++; $display("FAIL hs_req_stable: got %0d exp 4", req_cycles); end
        checks++; if (mem_wd !== 32'hABCD_ABCD || be !== 4'b1100) begin errors++; $display("FAIL hs_lanes: got %h/%b exp abcdabcd/1100", mem_wd, be); end
        tick();
        checks++; if (stall_cycles != 5) begin errors++; $display("FAIL hs_stall_cycles: got %0d exp 5", stall_cycles); end
        checks++; if (wb_data !== 32'h202 || wb_out !== 1'b0) begin errors++; $display("FAIL hs_wb: got %h/%b exp 00000202/0", wb_data, wb_out); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int starts0;
        starts0 = req_starts;
        alu = 32'h0; valid = 1; mask = 3'b101; rw = 1; wb_in = 1; waddr_in = 3;
        rdata = 32'h0000_8001;
        tick();
        ready = 1;
        tick();
        ready = 0;
        checks++; if (req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL b2b_done: got req=%b stall=%b exp 0/0", req, stall); end
        tick();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL b2b_noreissue: got %b exp 0", req); end
        checks++; if (wb_data !== 32'h0000_8001 || wb_out !== 1'b1 || waddr_out !== 5'd3) begin errors++; $display("FAIL b2b_first: got %h/%b/%0d exp 00008001/1/3", wb_data, wb_out, waddr_out); end
        alu = 32'h10; mask = 3'b010; waddr_in = 4; rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_second_stall: got %b exp 1", stall); end
        tick();
        checks++; if (be !== 4'b1111 || mem_addr !== 32'h10) begin errors++; $display("FAIL b2b_second_bus: got %b/%h exp 1111/00000010", be, mem_addr); end
        ready = 1;
        tick();
        ready = 0;
        tick();
        checks++; if (wb_data !== 32'hDEAD_BEEF || waddr_out !== 5'd4) begin errors++; $display("FAIL b2b_second: got %h/%0d exp deadbeef/4", wb_data, waddr_out); end
        checks++; if (req_starts - starts0 != 2) begin errors++; $display("FAIL b2b_req_count: got %0d exp 2", req_starts - starts0); end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_extract();
        logic [2:0]  v_mask [4] = '{3'b000, 3'b100, 3'b001, 3'b010};
        logic [31:0] v_addr [4] = '{32'h1, 32'h2, 32'h2, 32'h4};
        logic [31:0] v_rd   [4] = '{32'h0000_7F00, 32'h00AB_0000, 32'h8000_1234, 32'h1234_5678};
        logic [31:0] v_exp  [4] = '{32'h0000_007F, 32'h0000_00AB, 32'hFFFF_8000, 32'h1234_5678};
        for (int i = 0; i < 4; i++) begin
            alu = v_addr[i]; valid = 1; mask = v_mask[i]; rw = 1; wb_in = 1; waddr_in = 9;
            rdata = v_rd[i];
            tick();
            ready = 1;
            tick();
            ready = 0;
            tick();
            checks++; if (wb_data !== v_exp[i]) begin errors++; $display("FAIL extract_%0d: got %h exp %h", i, wb_data, v_exp[i]); end
            idle_inputs();
            tick();
        end
    endtask

    task automatic test_reset_mid_busy();
        alu = 32'h40; valid = 1; mask = 3'b010; rw = 1; wb_in = 1; waddr_in = 2;
        rdata = 32'hCAFE_F00D;
        tick();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL rmb_busy_req: got %b exp 1", req); end
        rst = 1;
        #1;
        checks++; if (req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rmb_reset: got req=%b stall=%b exp 0/0", req, stall); end
        checks++; if (wb_data !== 32'h0 || wb_out !== 1'b0 || waddr_out !== 5'd0) begin errors++; $display("FAIL rmb_wb: got %h/%b/%0d exp 0/0/0", wb_data, wb_out, waddr_out); end
        tick();
        rst = 0;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rmb_restart_stall: got %b exp 1", stall); end
        tick();
        checks++; if (req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL rmb_restart_req: got %b/%h exp 1/00000040", req, mem_addr); end
        ready = 1;
        tick();
        ready = 0;
        tick();
        checks++; if (wb_data !== 32'hCAFE_F00D || wb_out !== 1'b1) begin errors++; $display("FAIL rmb_restart_data: got %h/%b exp cafef00d/1", wb_data, wb_out); end
        idle_inputs();
        tick();
    endtask

    task automatic test_misaligned();
        alu = 32'h6; valid = 1; mask = 3'b010; rw = 1; wb_in = 1; waddr_in = 6;
        rdata = 32'h1111_2222;
`ifdef MEM_ALIGN_CHECK_EN
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b exp 0", stall); end
        tick();
        checks++; if (req !== 1'b0 || misaligned !== 1'b1 || wb_out !== 1'b0) begin errors++; $display("FAIL mis_trap: got req=%b mis=%b wb=%b exp 0/1/0", req, misaligned, wb_out); end
        idle_inputs();
        tick();
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b exp 0", misaligned); end
`else
        tick();
        checks++; if (req !== 1'b1 || mem_addr !== 32'h4 || be !== 4'b1111 || misaligned !== 1'b0) begin errors++; $display("FAIL nomis_bus: got req=%b addr=%h be=%b mis=%b exp 1/00000004/1111/0", req, mem_addr, be, misaligned); end
        ready = 1;
        tick();
        ready = 0;
        tick();
        checks++; if (wb_data !== 32'h1111_2222 || misaligned !== 1'b0) begin errors++; $display("FAIL nomis_data: got %h/%b exp 11112222/0", wb_data, misaligned); end
        idle_inputs();
        tick();
`endif
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_non_mem();
        test_signed_byte_load();
        test_half_store();
        test_back_to_back();
        test_load_extract();
        test_reset_mid_busy();
        test_misaligned();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
